// File: rtl/dose_scheduler.sv
// Dose slot table matched against time-of-day, plus the dispense/alert sequencer
// that drives the mechanism handshake, the patient alarm and the missed-dose count.
module dose_scheduler #(
    parameter int unsigned NUM_SLOTS   = 4,
    parameter int unsigned TIMEOUT_SEC = 300,
    localparam int unsigned SW         = $clog2(NUM_SLOTS)
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 sec_pulse,
    input  logic [4:0]           cur_hours,
    input  logic [5:0]           cur_minutes,
    input  logic [5:0]           cur_seconds,
    input  logic                 prog_we,
    input  logic [SW-1:0]        prog_slot,
    input  logic [4:0]           prog_hours,
    input  logic [5:0]           prog_minutes,
    input  logic [1:0]           prog_comp,
    input  logic                 prog_en,
    input  logic                 dispense_done,
    input  logic                 taken,
    output logic                 dispense_req,
    output logic [1:0]           dispense_comp,
    output logic                 alarm,
    output logic [SW-1:0]        active_slot,
    output logic [7:0]           missed_count,
    output logic [NUM_SLOTS-1:0] pending
);

    localparam logic [11:0] TimeoutLast = 12'(TIMEOUT_SEC - 1);

    typedef enum logic [1:0] {StIdle, StDispense, StWaitRel, StAlert} state_e;

    state_e state_q, state_d;

    logic [NUM_SLOTS-1:0] en_q;
    logic [NUM_SLOTS-1:0] armed_q;
    logic [4:0]           hours_q   [NUM_SLOTS];
    logic [5:0]           minutes_q [NUM_SLOTS];
    logic [1:0]           comp_q    [NUM_SLOTS];

    logic [NUM_SLOTS-1:0] match;
    logic [NUM_SLOTS-1:0] time_eq;
    logic [NUM_SLOTS-1:0] pending_d;
    logic [SW-1:0]        sel;
    logic [1:0]           sel_comp;
    logic                 serve;

    logic [11:0] sec_cnt_q, sec_cnt_d;
    logic        miss_inc;

    logic          req_d;
    logic          alarm_d;
    logic [1:0]    comp_d;
    logic [SW-1:0] active_d;
    logic [7:0]    missed_d;

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            time_eq[i] = (hours_q[i] == cur_hours) && (minutes_q[i] == cur_minutes);
            match[i]   = en_q[i] && armed_q[i] && time_eq[i] && (cur_seconds == 6'd0);
        end
    end

    // Armed drops on the firing edge and only returns once the minute differs,
    // so the whole second-0 window produces a single fire.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            en_q    <= '0;
            armed_q <= '1;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                hours_q[i]   <= '0;
                minutes_q[i] <= '0;
                comp_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (prog_we && (prog_slot == SW'(i))) begin
                    en_q[i]      <= prog_en;
                    hours_q[i]   <= prog_hours;
                    minutes_q[i] <= prog_minutes;
                    comp_q[i]    <= prog_comp;
                    armed_q[i]   <= 1'b1;
                end else if (match[i]) begin
                    armed_q[i] <= 1'b0;
                end else if (!time_eq[i]) begin
                    armed_q[i] <= 1'b1;
                end
            end
        end
    end

    // Lowest pending index wins.
    always_comb begin
        sel      = '0;
        sel_comp = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel      = SW'(i);
                sel_comp = comp_q[i];
            end
        end
        serve = (state_q == StIdle) && (|pending);
    end

    always_comb begin
        pending_d = pending;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (serve && (sel == SW'(i))) pending_d[i] = 1'b0;
            if (match[i])                 pending_d[i] = 1'b1;
            if (prog_we && (prog_slot == SW'(i))) pending_d[i] = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q   <= StIdle;
            sec_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sec_cnt_q <= sec_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sec_cnt_d = sec_cnt_q;
        miss_inc  = 1'b0;
        case (state_q)
            StIdle: begin
                if (|pending) state_d = StDispense;
            end
            StDispense: begin
                if (dispense_done) state_d = StWaitRel;
            end
            StWaitRel: begin
                if (!dispense_done) begin
                    state_d   = StAlert;
                    sec_cnt_d = '0;
                end
            end
            StAlert: begin
                // taken has priority over the final timeout strobe
                if (taken) begin
                    state_d = StIdle;
                end else if (sec_pulse) begin
                    if (sec_cnt_q == TimeoutLast) begin
                        state_d  = StIdle;
                        miss_inc = 1'b1;
                    end else begin
                        sec_cnt_d = sec_cnt_q + 12'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_d    = (state_q == StDispense) && !dispense_done;
        alarm_d  = (state_d == StAlert);
        comp_d   = serve ? sel_comp : dispense_comp;
        active_d = serve ? sel : active_slot;
        missed_d = (miss_inc && (missed_count != 8'hFF)) ? missed_count + 8'd1 : missed_count;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            dispense_req  <= 1'b0;
            dispense_comp <= '0;
            alarm         <= 1'b0;
            active_slot   <= '0;
            missed_count  <= '0;
            pending       <= '0;
        end else begin
            dispense_req  <= req_d;
            dispense_comp <= comp_d;
            alarm         <= alarm_d;
            active_slot   <= active_d;
            missed_count  <= missed_d;
            pending       <= pending_d;
        end
    end

endmodule

// File: tb/tb_dose_scheduler.sv
// Directed bench for dose_scheduler: slot matching, handshake, alarm timeout,
// missed-dose saturation, ordering of simultaneous slots and reset behaviour.
module tb_dose_scheduler;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       sec_pulse;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes;
    logic [5:0] cur_seconds;
    logic       prog_we;
    logic [1:0] prog_slot;
    logic [4:0] prog_hours;
    logic [5:0] prog_minutes;
    logic [1:0] prog_comp;
    logic       prog_en;
    logic       dispense_done;
    logic       taken;
    logic       dispense_req;
    logic [1:0] dispense_comp;
    logic       alarm;
    logic [1:0] active_slot;
    logic [7:0] missed_count;
    logic [3:0] pending;

    int total = 0;
    int bad   = 0;

    dose_scheduler #(
        .NUM_SLOTS  (4),
        .TIMEOUT_SEC(3)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .sec_pulse    (sec_pulse),
        .cur_hours    (cur_hours),
        .cur_minutes  (cur_minutes),
        .cur_seconds  (cur_seconds),
        .prog_we      (prog_we),
        .prog_slot    (prog_slot),
        .prog_hours   (prog_hours),
        .prog_minutes (prog_minutes),
        .prog_comp    (prog_comp),
        .prog_en      (prog_en),
        .dispense_done(dispense_done),
        .taken        (taken),
        .dispense_req (dispense_req),
        .dispense_comp(dispense_comp),
        .alarm        (alarm),
        .active_slot  (active_slot),
        .missed_count (missed_count),
        .pending      (pending)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_hours   = 5'(h);
        cur_minutes = 6'(m);
        cur_seconds = 6'(s);
    endtask

    task automatic write_slot(input int slot, input int h, input int m, input int c, input bit en);
        prog_we      = 1'b1;
        prog_slot    = 2'(slot);
        prog_hours   = 5'(h);
        prog_minutes = 6'(m);
        prog_comp    = 2'(c);
        prog_en      = en;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic pulse_sec();
        sec_pulse = 1'b1;
        tick();
        sec_pulse = 1'b0;
    endtask

    // Re-arm slot 0 (08:30) and run it through to ALERT.
    task automatic fire0();
        set_time(8, 31, 0);
        tick();
        set_time(8, 30, 0);
        tick(3);
        dispense_done = 1'b1;
        tick();
        dispense_done = 1'b0;
        tick();
    endtask

    int pend_cnt;
    int req_rises;
    logic req_prev;

    initial begin
        reset = 1'b0;
        sec_pulse = 1'b0;
        prog_we = 1'b0;
        prog_slot = '0;
        prog_hours = '0;
        prog_minutes = '0;
        prog_comp = '0;
        prog_en = 1'b0;
        dispense_done = 1'b0;
        taken = 1'b0;
        set_time(8, 29, 59);
        tick(2);
        reset = 1'b1;
        check_eq("rst_req", dispense_req, 0);
        check_eq("rst_comp", dispense_comp, 0);
        check_eq("rst_alarm", alarm, 0);
        check_eq("rst_active", active_slot, 0);
        check_eq("rst_missed", missed_count, 0);
        check_eq("rst_pending", pending, 0);

        // Basic dose at 08:30
        write_slot(0, 8, 30, 2, 1'b1);
        check_eq("pre_pending", pending, 0);
        set_time(8, 30, 0);
        tick();
        check_eq("match_pending", pending, 4'b0001);
        tick();
        check_eq("sel_req_low", dispense_req, 0);
        check_eq("sel_pending_clr", pending, 0);
        tick();
        check_eq("req_high", dispense_req, 1);
        check_eq("req_comp", dispense_comp, 2);
        dispense_done = 1'b1;
        tick();
        check_eq("req_drop", dispense_req, 0);
        tick(4);
        check_eq("waitrel_alarm", alarm, 0);
        dispense_done = 1'b0;
        tick();
        check_eq("alert_alarm", alarm, 1);
        taken = 1'b1;
        tick();
        taken = 1'b0;
        check_eq("taken_alarm", alarm, 0);
        check_eq("taken_missed", missed_count, 0);
        tick(2);
        check_eq("idle_req", dispense_req, 0);

        // Re-arm after minute change, then timeout after 3 strobes
        set_time(8, 31, 0);
        tick();
        set_time(8, 30, 0);
        tick();
        check_eq("rearm_pending", pending, 4'b0001);
        tick(2);
        dispense_done = 1'b1;
        tick();
        dispense_done = 1'b0;
        tick();
        check_eq("to_alarm0", alarm, 1);
        pulse_sec();
        tick();
        check_eq("to_alarm1", alarm, 1);
        pulse_sec();
        tick();
        check_eq("to_alarm2", alarm, 1);
        pulse_sec();
        check_eq("to_alarm3", alarm, 0);
        check_eq("to_missed1", missed_count, 1);

        // taken together with the final strobe: no miss
        fire0();
        check_eq("tie_alarm_on", alarm, 1);
        pulse_sec();
        pulse_sec();
        sec_pulse = 1'b1;
        taken = 1'b1;
        tick();
        sec_pulse = 1'b0;
        taken = 1'b0;
        check_eq("tie_alarm", alarm, 0);
        check_eq("tie_missed", missed_count, 1);

        // Saturation
        for (int n = 0; n < 254; n++) begin
            fire0();
            pulse_sec();
            pulse_sec();
            pulse_sec();
        end
        check_eq("missed_255", missed_count, 255);
        fire0();
        pulse_sec();
        pulse_sec();
        pulse_sec();
        check_eq("missed_sat", missed_count, 255);

        // Held second 0 for 1000 cycles: one fire; rewrite slot 0 mid-dispense
        set_time(8, 31, 0);
        tick();
        set_time(8, 30, 0);
        pend_cnt = 0;
        req_rises = 0;
        req_prev = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            prog_we = (i == 500);
            prog_slot = 2'd0;
            prog_hours = 5'd9;
            prog_minutes = 6'd0;
            prog_comp = 2'd1;
            prog_en = 1'b1;
            tick();
            if (pending[0]) pend_cnt++;
            if (dispense_req && !req_prev) req_rises++;
            req_prev = dispense_req;
        end
        prog_we = 1'b0;
        check_eq("hold_pend_cnt", pend_cnt, 1);
        check_eq("hold_req_rises", req_rises, 1);
        check_eq("rewrite_req", dispense_req, 1);
        check_eq("rewrite_comp", dispense_comp, 2);
        dispense_done = 1'b1;
        tick();
        dispense_done = 1'b0;
        tick();
        check_eq("rewrite_alarm", alarm, 1);
        taken = 1'b1;
        tick();
        taken = 1'b0;

        // Slots 1 and 3 at 12:00
        write_slot(1, 12, 0, 1, 1'b1);
        write_slot(3, 12, 0, 3, 1'b1);
        set_time(11, 59, 59);
        tick();
        set_time(12, 0, 0);
        tick();
        check_eq("dual_pending", pending, 4'b1010);
        tick();
        check_eq("dual_pending1", pending, 4'b1000);
        tick();
        check_eq("dual_req1", dispense_req, 1);
        check_eq("dual_active1", active_slot, 1);
        check_eq("dual_comp1", dispense_comp, 1);
        set_time(12, 1, 0);
        dispense_done = 1'b1;
        tick();
        dispense_done = 1'b0;
        tick();
        check_eq("dual_alarm1", alarm, 1);
        taken = 1'b1;
        tick();
        taken = 1'b0;
        tick(2);
        check_eq("dual_req3", dispense_req, 1);
        check_eq("dual_active3", active_slot, 3);
        check_eq("dual_comp3", dispense_comp, 3);
        check_eq("dual_pending3", pending, 0);

        // Disable slot 2 while pending
        write_slot(2, 12, 1, 0, 1'b1);
        tick();
        check_eq("s2_pending", pending, 4'b0100);
        write_slot(2, 12, 1, 0, 1'b0);
        check_eq("s2_cleared", pending, 0);
        tick(2);
        check_eq("s2_stay_clr", pending, 0);
        dispense_done = 1'b1;
        tick();
        dispense_done = 1'b0;
        tick();
        taken = 1'b1;
        tick();
        taken = 1'b0;
        tick(4);
        check_eq("s2_no_req", dispense_req, 0);

        // Reset during ALERT
        write_slot(1, 12, 5, 2, 1'b1);
        set_time(12, 4, 59);
        tick();
        set_time(12, 5, 0);
        tick(3);
        dispense_done = 1'b1;
        tick();
        dispense_done = 1'b0;
        tick();
        check_eq("ra_alarm_on", alarm, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_eq("ra_alarm", alarm, 0);
        check_eq("ra_req", dispense_req, 0);
        check_eq("ra_comp", dispense_comp, 0);
        check_eq("ra_active", active_slot, 0);
        check_eq("ra_missed", missed_count, 0);
        check_eq("ra_pending", pending, 0);

        // Reset during DISPENSE
        write_slot(3, 12, 6, 3, 1'b1);
        set_time(12, 5, 59);
        tick();
        set_time(12, 6, 0);
        tick(3);
        check_eq("rd_req_on", dispense_req, 1);
        check_eq("rd_comp_on", dispense_comp, 3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_eq("rd_req", dispense_req, 0);
        check_eq("rd_comp", dispense_comp, 0);
        check_eq("rd_active", active_slot, 0);
        check_eq("rd_pending", pending, 0);

        // Table disabled after reset
        set_time(12, 5, 59);
        tick();
        set_time(12, 6, 0);
        tick(3);
        check_eq("dis_pending", pending, 0);
        check_eq("dis_req", dispense_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
